// File: rtl/da2_wavegen.sv
// da2_wavegen: tick-paced waveform generator feeding a DAC interface
// Produces constant/saw/triangle/square samples and hands them off via update.
module da2_wavegen (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [1:0]  mode,
   input  logic [11:0] step,
   input  logic [15:0] period,
   input  logic        dac_busy,
   input  logic        clr_ovr,
   output logic [11:0] val,
   output logic        update,
   output logic        overrun
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      ACK   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_q;
   logic [15:0] cnt_q, cnt_d;
   logic [11:0] acc_q, acc_d;
   logic        dir_q, dir_d;
   logic [11:0] val_q;
   logic        upd_q;
   logic        ovr_q;
   logic        tick;
   logic [12:0] sum;

   assign val     = val_q;
   assign update  = upd_q;
   assign overrun = ovr_q;

   // Sample tick divider: one tick every period+1 enabled cycles
   always_comb begin
      tick  = en && (cnt_q == period);
      cnt_d = cnt_q + 16'd1;
      if (!en || tick) begin
         cnt_d = 16'd0;
      end
   end

   // Next sample and direction for the selected waveform
   always_comb begin
      acc_d = acc_q;
      dir_d = 1'b0;
      sum   = {1'b0, acc_q} + {1'b0, step};
      unique case (mode)
         2'b00: acc_d = step;
         2'b01: acc_d = sum[11:0];
         2'b10: begin
            if (!dir_q) begin
               if (sum >= 13'd4095) begin
                  acc_d = 12'hFFF;
                  dir_d = 1'b1;
               end else begin
                  acc_d = sum[11:0];
               end
            end else begin
               if (acc_q <= step) begin
                  acc_d = 12'h000;
               end else begin
                  acc_d = acc_q - step;
                  dir_d = 1'b1;
               end
            end
         end
         2'b11: acc_d = (acc_q == 12'h000) ? 12'hFFF : 12'h000;
      endcase
   end

   // Counter and waveform state; acc advances on every tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 16'd0;
         acc_q <= 12'h000;
         dir_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (tick) begin
            acc_q <= acc_d;
            dir_q <= dir_d;
         end
      end
   end

   // Transfer handshake FSM with registered val/update/overrun
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         val_q   <= 12'h000;
         upd_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         upd_q <= 1'b0;
         if (tick && (state_q != IDLE)) begin
            ovr_q <= 1'b1;
         end else if (clr_ovr) begin
            ovr_q <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               if (tick) begin
                  val_q   <= acc_d;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (!dac_busy) begin
                  upd_q   <= 1'b1;
                  state_q <= ACK;
               end
            end
            ACK: begin
               if (dac_busy) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (!dac_busy) begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_da2_wavegen.sv
// tb_da2_wavegen: scoreboard bench for the waveform generator
// A tick-level model pushes expected samples; the monitor pops them on update.
module tb_da2_wavegen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [11:0] step = 12'h000;
   logic [15:0] period = 16'd0;
   logic        dac_busy = 1'b0;
   logic        clr_ovr = 1'b0;
   logic [11:0] val;
   logic        update;
   logic        overrun;

   typedef struct {
      int          stamp;
      logic [11:0] v;
   } exp_t;

   exp_t        q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          ntick = 0;
   int          n_upd = 0;
   int          upd_cyc = 0;
   int          prev_cyc = 0;
   logic [11:0] last_val = 12'h000;
   int          slack = 0;
   bit          busy_auto = 1'b0;
   int          busy_len = 34;
   int          busy_cnt = 0;

   int          cnt_m = 0;
   int          acc_m = 0;
   bit          dir_m = 1'b0;

   da2_wavegen dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step),
      .period(period), .dac_busy(dac_busy), .clr_ovr(clr_ovr),
      .val(val), .update(update), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Reference model of the tick divider and sample generator
   initial forever begin
      int   nx;
      exp_t e;
      @(posedge clk);
      cyc++;
      if (rst) begin
         cnt_m = 0; acc_m = 0; dir_m = 1'b0;
      end else if (!en) begin
         cnt_m = 0;
      end else if (cnt_m == int'(period)) begin
         cnt_m = 0;
         nx = acc_m;
         case (mode)
            2'b00: nx = int'(step);
            2'b01: nx = (acc_m + int'(step)) % 4096;
            2'b10: begin
               if (!dir_m) begin
                  nx = acc_m + int'(step);
                  if (nx >= 4095) begin nx = 4095; dir_m = 1'b1; end
               end else begin
                  nx = acc_m - int'(step);
                  if (nx <= 0) begin nx = 0; dir_m = 1'b0; end
               end
            end
            default: nx = (acc_m == 0) ? 4095 : 0;
         endcase
         if (mode != 2'b10) dir_m = 1'b0;
         acc_m = nx;
         e.stamp = cyc;
         e.v = 12'(nx);
         q.push_back(e);
         ntick++;
      end else begin
         cnt_m++;
      end
   end

   // Monitor: each update must carry the sample of the tick that issued it
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (update === 1'b1) begin
         n_upd++;
         prev_cyc = upd_cyc;
         upd_cyc = cyc;
         last_val = val;
         while (q.size() > 0 && q[0].stamp < cyc - 1 - slack)
            void'(q.pop_front());
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL sb_empty: update val=%h at cycle %0d, required no update", val, cyc);
         end else begin
            e = q.pop_front();
            if (e.stamp > cyc - 1 || val !== e.v) begin
              fails++;
              $display("FAIL sb_val: got %h at cycle %0d, required %h from tick %0d",
                       val, cyc, e.v, e.stamp);
            end
         end
      end
   end

   // DAC busy pulse: starts one cycle after update, lasts busy_len cycles
   initial forever begin
      @(negedge clk);
      if (busy_auto) begin
         if (busy_cnt > 0) begin
            dac_busy = 1'b1;
            busy_cnt--;
         end else begin
            dac_busy = 1'b0;
         end
         if (update === 1'b1) busy_cnt = busy_len;
      end
   end

   task automatic wait_upd(input int n, input int budget, output bit ok);
      int start;
      start = n_upd;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (n_upd - start >= n) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_tick(input int budget, output bit ok);
      int t0;
      t0 = ntick;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (ntick != t0) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      en = 1'b0;
      repeat (2) @(negedge clk);
      q.delete();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests++;
      if (val !== 12'h000) begin
         fails++; $display("FAIL rst_val: got %h required 000", val);
      end
      tests++;
      if (update !== 1'b0) begin
         fails++; $display("FAIL rst_update: got %b required 0", update);
      end
      tests++;
      if (overrun !== 1'b0) begin
         fails++; $display("FAIL rst_overrun: got %b required 0", overrun);
      end
      q.delete();
      rst = 1'b0;
   endtask

   task automatic test_saw_overrun();
      bit ok;
      int n0;
      mode = 2'b01; step = 12'h400; period = 16'd3;
      busy_len = 34; busy_auto = 1'b1; slack = 0;
      en = 1'b1;
      wait_upd(3, 400, ok);
      tests++;
      if (!ok) begin
         fails++; $display("FAIL ovr_updates: got timeout required 3 updates");
      end
      tests++;
      if (overrun !== 1'b1) begin
         fails++; $display("FAIL ovr_set: got %b required 1", overrun);
      end
      en = 1'b0;
      repeat (50) @(negedge clk);
      n0 = n_upd;
      repeat (30) @(negedge clk);
      tests++;
      if (n_upd != n0) begin
         fails++; $display("FAIL en_off_quiet: got %0d updates required %0d", n_upd, n0);
      end
      @(negedge clk);
      clr_ovr = 1'b1;
      @(negedge clk);
      clr_ovr = 1'b0;
      #1;
      tests++;
      if (overrun !== 1'b0) begin
         fails++; $display("FAIL ovr_clear: got %b required 0", overrun);
      end
   endtask

   task automatic test_saw_seq();
      logic [11:0] ex [5] = '{12'h400, 12'h800, 12'hC00, 12'h000, 12'h400};
      bit ok;
      do_reset();
      mode = 2'b01; step = 12'h400; period = 16'd63;
      busy_auto = 1'b1; slack = 0;
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_upd(1, 200, ok);
         tests++;
         if (!ok || last_val !== ex[i]) begin
            fails++;
            $display("FAIL saw_val%0d: got %h ok=%0d required %h", i, last_val, ok, ex[i]);
         end
         if (i > 0) begin
            tests++;
            if (upd_cyc - prev_cyc != 64) begin
               fails++;
               $display("FAIL saw_gap%0d: got %0d required 64", i, upd_cyc - prev_cyc);
            end
         end
      end
      tests++;
      if (overrun !== 1'b0) begin
         fails++; $display("FAIL saw_no_ovr: got %b required 0", overrun);
      end
      en = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_triangle();
      logic [11:0] ex [7] = '{12'h600, 12'hC00, 12'hFFF, 12'h9FF,
                              12'h3FF, 12'h000, 12'h600};
      bit ok;
      do_reset();
      mode = 2'b10; step = 12'h600; period = 16'd63;
      busy_auto = 1'b1; slack = 0;
      en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         wait_upd(1, 200, ok);
         tests++;
         if (!ok || last_val !== ex[i]) begin
            fails++;
            $display("FAIL tri_val%0d: got %h ok=%0d required %h", i, last_val, ok, ex[i]);
         end
      end
      en = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_square_const();
      logic [11:0] ex [6] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h123, 12'h123};
      bit ok;
      do_reset();
      mode = 2'b11; step = 12'h000; period = 16'd99;
      busy_auto = 1'b1; slack = 0;
      en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_upd(1, 250, ok);
         tests++;
         if (!ok || last_val !== ex[i]) begin
            fails++;
            $display("FAIL sq_const%0d: got %h ok=%0d required %h", i, last_val, ok, ex[i]);
         end
         if (i == 3) begin
            mode = 2'b00; step = 12'h123;
         end
      end
      en = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_busy_stall();
      bit ok;
      bit seen;
      int n0;
      do_reset();
      busy_auto = 1'b0; slack = 20;
      dac_busy = 1'b1;
      mode = 2'b00; step = 12'h055; period = 16'd9;
      en = 1'b1;
      wait_tick(50, ok);
      en = 1'b0;
      tests++;
      if (!ok) begin
         fails++; $display("FAIL stall_tick: got timeout required tick");
      end
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (update !== 1'b0) seen = 1'b1;
      end
      tests++;
      if (seen) begin
         fails++; $display("FAIL stall_hold: got update=1 required 0 while busy");
      end
      n0 = n_upd;
      dac_busy = 1'b0;
      @(negedge clk);
      #1;
      tests++;
      if (update !== 1'b1 || val !== 12'h055) begin
         fails++; $display("FAIL stall_issue: got upd=%b val=%h required 1 055", update, val);
      end
      @(negedge clk);
      #1;
      tests++;
      if (update !== 1'b0) begin
         fails++; $display("FAIL stall_pulse: got %b required 0", update);
      end
      dac_busy = 1'b1;
      repeat (3) @(negedge clk);
      dac_busy = 1'b0;
      repeat (20) @(negedge clk);
      tests++;
      if (n_upd != n0 + 1 || overrun !== 1'b0) begin
         fails++;
         $display("FAIL stall_done: got %0d updates ovr=%b required %0d 0",
                  n_upd - n0, overrun, 1);
      end
      slack = 0;
   endtask

   task automatic test_rst_ack_clr();
      bit ok;
      do_reset();
      busy_auto = 1'b0; dac_busy = 1'b0; slack = 0;
      mode = 2'b00; step = 12'h321; period = 16'd7;
      en = 1'b1;
      wait_upd(1, 50, ok);
      wait_tick(20, ok);
      tests++;
      if (!ok || overrun !== 1'b1) begin
         fails++; $display("FAIL ack_ovr: got %b ok=%0d required 1", overrun, ok);
      end
      clr_ovr = 1'b1;
      wait_tick(20, ok);
      tests++;
      if (!ok || overrun !== 1'b1) begin
         fails++; $display("FAIL clr_vs_set: got %b ok=%0d required 1", overrun, ok);
      end
      @(negedge clk);
      #1;
      tests++;
      if (overrun !== 1'b0) begin
         fails++; $display("FAIL clr_after: got %b required 0", overrun);
      end
      clr_ovr = 1'b0;
      wait_tick(20, ok);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (val !== 12'h000 || update !== 1'b0 || overrun !== 1'b0) begin
         fails++;
         $display("FAIL rst_ack: got val=%h upd=%b ovr=%b required 000 0 0",
                  val, update, overrun);
      end
      en = 1'b0;
      repeat (2) @(negedge clk);
      q.delete();
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_saw_overrun();
      test_saw_seq();
      test_triangle();
      test_square_const();
      test_busy_stall();
      test_rst_ack_clr();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/da2_wavegen.md
DA2_WAVEGEN -- requirements
Module: da2_wavegen

Interface
REQ-001 SHALL have ports: clk input 1, system clock; all logic on rising edge.
REQ-002 SHALL have ports: rst input 1, reset, asynchronous, active-high.
REQ-003 SHALL have ports: en input 1, generator enable.
REQ-004 SHALL have ports: mode input 2, waveform: 00 constant, 01 sawtooth, 10 triangle, 11 square.
REQ-005 SHALL have ports: step input 12, increment per tick (saw/triangle) or level (constant).
REQ-006 SHALL have ports: period input 16, sample tick divider; tick every period+1 clk cycles.
REQ-007 SHALL have ports: dac_busy input 1, high while downstream DAC interface is shifting (driven from inverted SYNC).
REQ-008 SHALL have ports: clr_ovr input 1, clears overrun flag.
REQ-009 SHALL have ports: val output 12, sample presented to DAC interface, stable outside ISSUE.
REQ-010 SHALL have ports: update output 1, single-cycle request to DAC interface.
REQ-011 SHALL have ports: overrun output 1, sticky flag, a tick occurred while a transfer was in progress.

Function
REQ-012 SHALL run a 16-bit tick counter: en=1 counts 0..period, asserts internal tick on the cycle count==period, then wraps to 0; period=0 -> tick every cycle; en=0 holds counter at 0, no ticks.
REQ-013 SHALL keep a 12-bit accumulator acc and a direction bit dir (0=up), advanced only on tick.
REQ-014 SHALL compute next sample on tick: mode 00 -> step; 01 -> (acc+step) mod 4096, wrap-around allowed; 10 -> up: acc+step saturated at 4095, dir<=1 when 4095 is reached; down: acc-step saturated at 0, dir<=0 when 0 is reached; 11 -> 0xFFF if acc==0 else 0x000 (toggles each tick).
REQ-015 SHALL write the next sample into acc on every tick regardless of transfer state.
REQ-016 SHALL use FSM states IDLE, ISSUE, ACK, DONE.
REQ-017 IDLE + tick: val<=next sample, go ISSUE.
REQ-018 ISSUE: update=1 for exactly one cycle when dac_busy=0, then go ACK; if dac_busy=1, hold ISSUE with update=0.
REQ-019 ACK: wait for dac_busy=1, then go DONE.
REQ-020 DONE: wait for dac_busy=0, then go IDLE; next transfer can issue on following tick.
REQ-021 Tick in any state other than IDLE SHALL set overrun=1, leave val unchanged, and still advance acc (frequency preserved, sample dropped).
REQ-022 clr_ovr=1 SHALL clear overrun next cycle; simultaneous clr_ovr and overrun-causing tick -> overrun=1 (set wins).
REQ-023 mode/step/period changes SHALL take effect at the next tick without resetting acc; dir reset to 0 on any tick where mode!=10.
REQ-024 en 1->0 SHALL let an in-flight transfer complete through DONE to IDLE; no new transfers issue.
REQ-025 Latency: tick to update assertion SHALL be exactly 2 cycles when dac_busy=0.

Reset
REQ-026 rst=1 SHALL immediately force val=0, update=0, overrun=0, acc=0, dir=0, counter=0, state IDLE, including mid-transfer.
REQ-027 After rst release, first tick SHALL occur period+1 cycles after en is high.

Verification
REQ-028 mode=01, step=0x400, period=3, dac_busy modelled as 34-cycle pulse starting 1 cycle after update -> overrun=1 and acc still advancing 0x400 per tick; period=63 -> val sequence 0x400,0x800,0xC00,0x000,0x400, update once per 64 cycles, overrun=0.
REQ-029 mode=10, step=0x600, period=63 -> val 0x600,0xC00,0xFFF,0x9FF,0x3FF,0x000,0x600.
REQ-030 mode=11, period=99 -> val alternates 0xFFF,0x000; mode=00 step=0x123 -> val=0x123 each tick.
REQ-031 dac_busy held high when tick occurs in IDLE -> state ISSUE, update=0 until dac_busy falls, then one-cycle update.
REQ-032 rst asserted during ACK -> val=0, update=0, overrun=0 same cycle; clr_ovr coincident with overrun tick -> overrun stays 1.
